idex_skid_stage: RTL and testbench

- Parametrised ID/EX pipeline stage for the lab CPU datapath; sits between decode and execute.
- Carries rd/rs/rt, sign-extended immediate, ALU op and write-back control bits.
- Adds a valid/ready handshake, a 2-entry skid buffer so that back-pressure from EX never loses an instruction, synchronous flush for branch squash, and a saturating stall counter.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/skid_buffer.sv | 103 ++++++++++
 rtl/idex_skid_stage.sv | 100 ++++++++++
 tb/tb_idex_skid_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the lab CPU: field widths, control-bit
// positions and the ID/EX payload layout.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ALUOP_W    = 4;
  localparam int unsigned CTRL_W     = 3;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;

  // ctrl sits in the least-significant bits so a flush mask is a simple low-bit mask.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rs;
    logic [DATA_W-1:0]     rt;
    logic [DATA_W-1:0]     imm;
    logic [ALUOP_W-1:0]    aluop;
    logic [CTRL_W-1:0]     ctrl;
  } idex_payload_t;

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer. Output is driven from the main
// register only; the skid register catches the one beat that arrives while
// the consumer stalls. Flush drops both entries and clears FlushMask bits in
// the main register.
module skid_buffer #(
  parameter int unsigned     Width     = 8,
  parameter logic [Width-1:0] FlushMask = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  // Encoded as {main_v, skid_v}; StIllegal is unreachable and recovers to empty.
  typedef enum logic [1:0] {
    StEmpty   = 2'b00,
    StIllegal = 2'b01,
    StOne     = 2'b10,
    StFull    = 2'b11
  } state_e;

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             push, pop;
  state_e           state;

  assign state     = state_e'({main_v_q, skid_v_q});
  assign in_ready  = !skid_v_q && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = main_v_q && out_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

  // Next-state: fill/drain the two entries, flush overriding everything.
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = main_q & ~FlushMask;
    end else begin
      unique case (state)
        StEmpty: begin
          if (push) begin
            main_d   = in_data;
            main_v_d = 1'b1;
          end
        end
        StOne: begin
          if (pop && push) begin
            main_d = in_data;
          end else if (pop) begin
            main_v_d = 1'b0;
          end else if (push) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
          end
        end
        StFull: begin
          if (pop) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        StIllegal: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline stage: skid-buffered decode->execute handoff with bubble
// gating of control bits and a saturating count of back-pressured cycles.
module idex_skid_stage #(
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned ALUOP_W    = cpu_pkg::ALUOP_W,
  parameter int unsigned CTRL_W     = cpu_pkg::CTRL_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0]     rs_in,
  input  logic [DATA_W-1:0]     rt_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [ALUOP_W-1:0]    aluop_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0]     rs_out,
  output logic [DATA_W-1:0]     rt_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [ALUOP_W-1:0]    aluop_out,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Same layout as cpu_pkg::idex_payload_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rs;
    logic [DATA_W-1:0]     rt;
    logic [DATA_W-1:0]     imm;
    logic [ALUOP_W-1:0]    aluop;
    logic [CTRL_W-1:0]     ctrl;
  } payload_t;

  localparam int unsigned PayloadW = $bits(payload_t);
  // Flush clears only the ctrl bits of the held instruction; data fields are left as-is.
  localparam logic [PayloadW-1:0] CtrlMask = {{(PayloadW - CTRL_W){1'b0}}, {CTRL_W{1'b1}}};

  payload_t           in_pl;
  payload_t           out_pl;
  logic               buf_out_valid;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  assign in_pl.rd    = rd_in;
  assign in_pl.rs    = rs_in;
  assign in_pl.rt    = rt_in;
  assign in_pl.imm   = imm_in;
  assign in_pl.aluop = aluop_in;
  assign in_pl.ctrl  = ctrl_in;

  skid_buffer #(
    .Width     (PayloadW),
    .FlushMask (CtrlMask)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (buf_out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign out_valid = buf_out_valid;
  assign rd_out    = out_pl.rd;
  assign rs_out    = out_pl.rs;
  assign rt_out    = out_pl.rt;
  assign imm_out   = out_pl.imm;
  assign aluop_out = out_pl.aluop;
  // A bubble must never carry regwrite/memwrite/memread into EX.
  assign ctrl_out  = buf_out_valid ? out_pl.ctrl : '0;
  assign stall_cnt = stall_cnt_q;

  // Count back-pressured cycles, sticking at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (buf_out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Directed bench for idex_skid_stage with a queue scoreboard of held instructions.
module tb_idex_skid_stage;

  typedef struct {
    logic [5:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [2:0]  ctrl;
  } pl_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  rd_in, rd_out;
  logic [31:0] rs_in, rt_in, imm_in, rs_out, rt_out, imm_out;
  logic [3:0]  aluop_in, aluop_out;
  logic [2:0]  ctrl_in, ctrl_out;
  logic [15:0] stall_cnt;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [5:0]  s_rd_out;
  logic [31:0] s_rs_out, s_rt_out, s_imm_out;
  logic [3:0]  s_aluop_out;
  logic [2:0]  s_ctrl_out;
  logic [3:0]  s_stall;

  int   tests = 0;
  int   fails = 0;
  int   exp_stall = 0;
  pl_t  mq[$];

  idex_skid_stage u_dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .rd_in (rd_in), .rs_in (rs_in), .rt_in (rt_in), .imm_in (imm_in),
    .aluop_in (aluop_in), .ctrl_in (ctrl_in),
    .out_valid (out_valid), .out_ready (out_ready),
    .rd_out (rd_out), .rs_out (rs_out), .rt_out (rt_out), .imm_out (imm_out),
    .aluop_out (aluop_out), .ctrl_out (ctrl_out), .stall_cnt (stall_cnt)
  );

  idex_skid_stage #(.CNT_W (4)) u_sat (
    .clk (clk), .rst_n (rst_n), .flush (s_flush),
    .in_valid (s_in_valid), .in_ready (s_in_ready),
    .rd_in (rd_in), .rs_in (rs_in), .rt_in (rt_in), .imm_in (imm_in),
    .aluop_in (aluop_in), .ctrl_in (ctrl_in),
    .out_valid (s_out_valid), .out_ready (s_out_ready),
    .rd_out (s_rd_out), .rs_out (s_rs_out), .rt_out (s_rt_out), .imm_out (s_imm_out),
    .aluop_out (s_aluop_out), .ctrl_out (s_ctrl_out), .stall_cnt (s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] rd, input logic [31:0] rs,
                       input logic [2:0] ctrl);
    in_valid = v;
    rd_in    = rd;
    rs_in    = rs;
    rt_in    = rs ^ 32'hA5A5_0000;
    imm_in   = {{26{rd[5]}}, rd} - 32'd7;
    aluop_in = rd[3:0];
    ctrl_in  = ctrl;
  endtask

  // Check outputs against the scoreboard at the falling edge, then advance the model.
  task automatic cycle();
    pl_t cur;
    bit  exp_rdy, do_push, do_pop;
    @(negedge clk);
    exp_rdy = (mq.size() < 2) && !flush;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("stall_cnt", {48'd0, stall_cnt}, 64'(exp_stall));
    chk("legal_state", {63'd0, !(!u_dut.u_skid.main_v_q && u_dut.u_skid.skid_v_q)}, 64'd1);
    if (mq.size() > 0) begin
      chk("rd_out", {58'd0, rd_out}, {58'd0, mq[0].rd});
      chk("rs_out", {32'd0, rs_out}, {32'd0, mq[0].rs});
      chk("rt_out", {32'd0, rt_out}, {32'd0, mq[0].rt});
      chk("imm_out", {32'd0, imm_out}, {32'd0, mq[0].imm});
      chk("aluop_out", {60'd0, aluop_out}, {60'd0, mq[0].aluop});
      chk("ctrl_out", {61'd0, ctrl_out}, {61'd0, mq[0].ctrl});
    end else begin
      chk("ctrl_bubble", {61'd0, ctrl_out}, 64'd0);
    end
    cur.rd = rd_in; cur.rs = rs_in; cur.rt = rt_in; cur.imm = imm_in;
    cur.aluop = aluop_in; cur.ctrl = ctrl_in;
    do_push = in_valid && exp_rdy;
    do_pop  = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready && exp_stall < 65535) exp_stall++;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(cur);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 3'd0);
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
    chk("rst_ctrl", {61'd0, ctrl_out}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();

    // Streaming at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 6'(i), 32'h10 + 32'(i - 1), 3'(i));
      cycle();
    end
    drive(1'b0, 6'd0, 32'd0, 3'd0);
    repeat (2) cycle();

    // Back-pressure: A, B held, a third offer refused while full.
    out_ready = 1'b0;
    drive(1'b1, 6'd3, 32'h33, 3'b001); cycle();
    drive(1'b1, 6'd4, 32'h44, 3'b010); cycle();
    drive(1'b1, 6'd5, 32'h55, 3'b100); cycle();
    drive(1'b0, 6'd0, 32'd0, 3'd0);
    repeat (2) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Flush while full with C offered.
    out_ready = 1'b0;
    drive(1'b1, 6'd9, 32'h99, 3'b101); cycle();
    drive(1'b1, 6'd10, 32'hAA, 3'b110); cycle();
    flush = 1'b1;
    drive(1'b1, 6'd11, 32'hCC, 3'b001); cycle();
    flush = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 3'd0);
    cycle();
    out_ready = 1'b1;
    repeat (2) cycle();

    // Pop+push in ONE, then promotion out of FULL.
    drive(1'b1, 6'd20, 32'h200, 3'b011); cycle();
    drive(1'b1, 6'd21, 32'h210, 3'b100); cycle();
    drive(1'b1, 6'd22, 32'h220, 3'b111); cycle();
    drive(1'b0, 6'd0, 32'd0, 3'd0); cycle();
    out_ready = 1'b0;
    drive(1'b1, 6'd23, 32'h230, 3'b001); cycle();
    drive(1'b1, 6'd24, 32'h240, 3'b010); cycle();
    drive(1'b0, 6'd0, 32'd0, 3'd0); cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(1'b1, 6'd30, 32'h300, 3'b111); cycle();
    drive(1'b1, 6'd31, 32'h310, 3'b111); cycle();
    drive(1'b0, 6'd0, 32'd0, 3'd0);
    rst_n = 1'b0;
    #2;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_stall", {48'd0, stall_cnt}, 64'd0);
    chk("arst_ctrl", {61'd0, ctrl_out}, 64'd0);
    mq.delete();
    exp_stall = 0;
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (2) cycle();

    // Saturation on the 4-bit counter instance.
    drive(1'b1, 6'd40, 32'h400, 3'b001);
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 3'd0);
    chk("sat_valid", {63'd0, s_out_valid}, 64'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("sat_stall", {60'd0, s_stall}, (k < 15) ? 64'(k) : 64'd15);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
